// File: rtl/usb_rx_pkg.sv
// ============================================================================
// usb_rx_pkg
// Shared USB receive-path types and CRC16 constants (FSM state encoding,
// polynomial, seed and good-packet residual).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_rx_pkg;

  typedef enum logic [1:0] {
    DCRC_IDLE  = 2'd0,
    DCRC_ACCUM = 2'd1,
    DCRC_CHECK = 2'd2
  } dcrc_state_t;

  localparam logic [15:0] USB_CRC16_POLY  = 16'h8005;
  localparam logic [15:0] USB_CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] USB_CRC16_RESID = 16'h800D;

endpackage

`default_nettype wire

// File: rtl/usb_dcrc16_check_if.sv
// ============================================================================
// usb_dcrc16_check_if
// Bit-stream / verdict bundle between the RX datapath and the DATA CRC16
// checker. With USB_DCRC_ERRCNT_EN defined it also carries the error counter
// and its clear.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_dcrc16_check_if #(
  parameter int CNT_W = 11
) ();

  logic             dcrc_enable;
  logic             rx_bit;
  logic             dcrc_clear;
  logic             eop;
  logic [15:0]      crc_value;
  logic [CNT_W-1:0] bit_count;
  logic             crc_done;
  logic             crc_ok;
  logic             crc_err;
`ifdef USB_DCRC_ERRCNT_EN
  logic [7:0]       err_count;
  logic             err_count_clr;

  modport master (
    output dcrc_enable, rx_bit, dcrc_clear, eop, err_count_clr,
    input  crc_value, bit_count, crc_done, crc_ok, crc_err, err_count
  );

  modport slave (
    input  dcrc_enable, rx_bit, dcrc_clear, eop, err_count_clr,
    output crc_value, bit_count, crc_done, crc_ok, crc_err, err_count
  );
`else
  modport master (
    output dcrc_enable, rx_bit, dcrc_clear, eop,
    input  crc_value, bit_count, crc_done, crc_ok, crc_err
  );

  modport slave (
    input  dcrc_enable, rx_bit, dcrc_clear, eop,
    output crc_value, bit_count, crc_done, crc_ok, crc_err
  );
`endif

endinterface

`default_nettype wire

// File: rtl/usb_crc16_shift.sv
// ============================================================================
// usb_crc16_shift
// Combinational single-bit step of the USB CRC16 (x^16+x^15+x^2+1) register.
// Shared between the RX checker and the TX CRC generator.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_crc16_shift
  import usb_rx_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic fb;

  assign fb    = crc_i[15] ^ bit_i;
  assign crc_o = {crc_i[14:0], 1'b0} ^ (fb ? USB_CRC16_POLY : 16'h0000);

endmodule

`default_nettype wire

// File: rtl/usb_dcrc16_check.sv
// ============================================================================
// usb_dcrc16_check
// Serial USB DATA-packet CRC16 checker. Accumulates unstuffed data bits
// between dcrc_clear and eop, then issues a one-cycle crc_done with a sticky
// crc_ok / crc_err verdict for the RX controller.
// Optional feature macro: USB_DCRC_ERRCNT_EN (saturating failed-packet count).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_dcrc16_check
  import usb_rx_pkg::*;
#(
  parameter int          CNT_W     = 11,
  parameter logic [15:0] CRC_INIT  = USB_CRC16_INIT,
  parameter logic [15:0] CRC_RESID = USB_CRC16_RESID
) (
  input  logic              clk,
  input  logic              n_rst,
  usb_dcrc16_check_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  dcrc_state_t      state_q, state_d;
  logic [15:0]      crc_q, crc_d, crc_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;

  usb_crc16_shift u_shift (
    .crc_i (crc_q),
    .bit_i (bus.rx_bit),
    .crc_o (crc_shift)
  );

  // Next-state, CRC/count update and verdict; the verdict is taken from the
  // post-shift values so a bit arriving with eop is included.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;
    if (bus.dcrc_clear) begin
      state_d = DCRC_ACCUM;
      crc_d   = CRC_INIT;
      cnt_d   = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        DCRC_IDLE: begin
          state_d = DCRC_IDLE;
        end
        DCRC_ACCUM: begin
          if (bus.dcrc_enable) begin
            crc_d = crc_shift;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          if (bus.eop) begin
            state_d = DCRC_CHECK;
            done_d  = 1'b1;
            // A saturated count is never a byte multiple, but reject it
            // explicitly so the rule holds for any CNT_W.
            ok_d    = (crc_d == CRC_RESID) && (cnt_d >= MIN_BITS) &&
                      (cnt_d[2:0] == 3'b000) && (cnt_d != CNT_MAX);
            err_d   = ~ok_d;
          end
        end
        DCRC_CHECK: begin
          state_d = DCRC_IDLE;
        end
        default: begin
          state_d = DCRC_IDLE;
        end
      endcase
    end
  end

  // State, accumulator and verdict registers; reset clears everything at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= DCRC_IDLE;
      crc_q   <= CRC_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign bus.crc_value = crc_q;
  assign bus.bit_count = cnt_q;
  assign bus.crc_done  = done_q;
  assign bus.crc_ok    = ok_q;
  assign bus.crc_err   = err_q;

`ifdef USB_DCRC_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // Count failed verdicts; an increment in the same cycle beats the clear.
  always_comb begin
    errcnt_d = errcnt_q;
    if (done_d && err_d) begin
      if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end else if (bus.err_count_clr) begin
      errcnt_d = 8'h00;
    end
  end

  // Error counter register, cleared only by reset or err_count_clr.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) errcnt_q <= 8'h00;
    else        errcnt_q <= errcnt_d;
  end

  assign bus.err_count = errcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_dcrc16_check.sv
// ============================================================================
// tb_usb_dcrc16_check
// Randomized scoreboard bench for usb_dcrc16_check. The reference model
// works on whole bytes with the reflected CRC-16/USB algorithm and judges a
// packet good when its last two bytes equal the CRC of the preceding ones.
// Optional feature macro: USB_DCRC_ERRCNT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_dcrc16_check;

  localparam int CNT_W = 11;
  localparam int SAT   = (1 << CNT_W) - 1;

  typedef logic [7:0] byteq_t[$];
  typedef bit         bitq_t[$];
  typedef struct {
    int cyc;
    bit ok;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_errcnt = 0;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_dcrc16_check_if #(.CNT_W(CNT_W)) bus ();

  usb_dcrc16_check #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_crc16(input byteq_t data);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (data[i]) begin
      c = c ^ {8'h00, data[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bitq_t make_packet(input byteq_t payload);
    bitq_t       bits;
    logic [15:0] c;
    byteq_t      d;
    c = ref_crc16(payload);
    d = payload;
    d.push_back(c[7:0]);
    d.push_back(c[15:8]);
    foreach (d[i]) for (int b = 0; b < 8; b++) bits.push_back(d[i][b]);
    return bits;
  endfunction

  function automatic bit ref_ok(input bitq_t bits);
    byteq_t      by;
    logic [7:0]  v;
    logic [15:0] trailer;
    int          n;
    n = bits.size();
    if (n < 16 || (n % 8) != 0 || n >= SAT) return 1'b0;
    for (int i = 0; i < n / 8; i++) begin
      for (int b = 0; b < 8; b++) v[b] = bits[8 * i + b];
      by.push_back(v);
    end
    trailer[15:8] = by.pop_back();
    trailer[7:0]  = by.pop_back();
    return ref_crc16(by) == trailer;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.crc_done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: crc_done=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("crc_ok", {31'd0, bus.crc_ok}, {31'd0, mon_e.ok});
        check("crc_err", {31'd0, bus.crc_err}, {31'd0, !mon_e.ok});
        check("bit_count", {21'd0, bus.bit_count}, mon_e.cnt);
        if (mon_e.ok) check("crc_resid", {16'd0, bus.crc_value}, 32'h800D);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_bit = 1'($urandom);
      step();
    end
  endtask

  task automatic push_exp(input exp_t e);
    e.cyc = cyc + 1;
    sbq.push_back(e);
    if (!e.ok) exp_errcnt++;
  endtask

  task automatic pulse_clear();
    bus.dcrc_clear = 1'b1;
    step();
    bus.dcrc_clear = 1'b0;
  endtask

  task automatic shift_bits(input bitq_t bits, input int max_gap);
    foreach (bits[i]) begin
      idle_cycles(int'($urandom_range(max_gap, 0)));
      bus.dcrc_enable = 1'b1;
      bus.rx_bit      = bits[i];
      step();
      bus.dcrc_enable = 1'b0;
    end
  endtask

  task automatic send_packet(input bitq_t bits, input bit eop_same, input int max_gap);
    exp_t  e;
    bitq_t body;
    int    n;
    n      = bits.size();
    e.cyc  = 0;
    e.ok   = ref_ok(bits);
    e.cnt  = (n > SAT) ? SAT : n;
    body   = bits;
    pulse_clear();
    if (eop_same && n > 0) begin
      void'(body.pop_back());
      shift_bits(body, max_gap);
      idle_cycles(int'($urandom_range(max_gap, 0)));
      bus.dcrc_enable = 1'b1;
      bus.rx_bit      = bits[n - 1];
      bus.eop         = 1'b1;
    end else begin
      shift_bits(body, max_gap);
      idle_cycles(int'($urandom_range(max_gap, 0)));
      bus.eop = 1'b1;
    end
    push_exp(e);
    step();
    bus.dcrc_enable = 1'b0;
    bus.eop         = 1'b0;
    repeat (3) step();
    check("sticky_ok", {31'd0, bus.crc_ok}, {31'd0, e.ok});
    check("sticky_err", {31'd0, bus.crc_err}, {31'd0, !e.ok});
  endtask

  task automatic random_packets(input int num);
    byteq_t pl;
    bitq_t  bits;
    int     len;
    int     idx;
    for (int p = 0; p < num; p++) begin
      pl.delete();
      len = int'($urandom_range(6, 0));
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      bits = make_packet(pl);
      case ($urandom_range(3, 0))
        0: begin
          idx       = int'($urandom_range(bits.size() - 1, 0));
          bits[idx] = ~bits[idx];
        end
        1: repeat ($urandom_range(7, 1)) void'(bits.pop_back());
        default: ;
      endcase
      send_packet(bits, 1'($urandom), 2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_crc_value"}, {16'd0, bus.crc_value}, 32'hFFFF);
    check({tag, "_bit_count"}, {21'd0, bus.bit_count}, 0);
    check({tag, "_crc_done"}, {31'd0, bus.crc_done}, 0);
    check({tag, "_crc_ok"}, {31'd0, bus.crc_ok}, 0);
    check({tag, "_crc_err"}, {31'd0, bus.crc_err}, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    byteq_t pl;
    bitq_t  bits;
    bus.dcrc_enable = 1'b0;
    bus.rx_bit      = 1'b0;
    bus.dcrc_clear  = 1'b0;
    bus.eop         = 1'b0;
`ifdef USB_DCRC_ERRCNT_EN
    bus.err_count_clr = 1'b0;
`endif
    repeat (3) step();
    check_reset_outputs("in_reset");
    n_rst = 1'b1;
    step();
    check_reset_outputs("after_reset");

    // zero-length DATA packet: sixteen zero bits leave the good residual
    pl.delete();
    send_packet(make_packet(pl), 1'b0, 0);

    // bytes 00 01 02 03 with CRC, then one flipped data bit
    pl = '{8'h00, 8'h01, 8'h02, 8'h03};
    bits = make_packet(pl);
    send_packet(bits, 1'b0, 1);
    bits[5] = ~bits[5];
    send_packet(bits, 1'b0, 1);

    // last CRC bit arrives with eop
    bits = make_packet(pl);
    send_packet(bits, 1'b1, 0);

    // good CRC but wrong lengths: 15 and 17 bits
    pl.delete();
    bits = make_packet(pl);
    void'(bits.pop_back());
    send_packet(bits, 1'b0, 0);
    bits = make_packet(pl);
    bits.push_back(1'b0);
    send_packet(bits, 1'b0, 0);

    // eop and enable in IDLE: no verdict, count untouched
    bus.eop = 1'b1;
    step();
    bus.eop         = 1'b0;
    bus.dcrc_enable = 1'b1;
    repeat (3) step();
    bus.dcrc_enable = 1'b0;
    repeat (3) step();
    check("idle_bit_count", {21'd0, bus.bit_count}, 17);

    // clear after 20 bits, then a valid zero-length packet
    pulse_clear();
    bits.delete();
    for (int i = 0; i < 20; i++) bits.push_back(1'($urandom));
    shift_bits(bits, 1);
    send_packet(make_packet(pl), 1'b0, 1);

    random_packets(40);

    // saturating count: 2080 bits of otherwise valid packet
    pl.delete();
    for (int i = 0; i < 258; i++) pl.push_back(8'($urandom));
    send_packet(make_packet(pl), 1'b0, 0);

    // asynchronous reset in the middle of a packet
    pulse_clear();
    bits.delete();
    for (int i = 0; i < 10; i++) bits.push_back(1'($urandom));
    shift_bits(bits, 0);
    bus.dcrc_enable = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_errcnt = 0;
    bus.dcrc_enable = 1'b0;
    step();
    n_rst = 1'b1;
    bus.eop = 1'b1;
    step();
    bus.eop = 1'b0;
    repeat (3) step();
    check_reset_outputs("post_reset_eop");

`ifdef USB_DCRC_ERRCNT_EN
    random_packets(6);
    check("errcnt_running", {24'd0, bus.err_count}, (exp_errcnt > 255) ? 255 : exp_errcnt);
    for (int p = 0; p < 300; p++) begin
      bits.delete();
      for (int i = 0; i < 8; i++) bits.push_back(1'($urandom));
      send_packet(bits, 1'b0, 0);
    end
    check("errcnt_sat", {24'd0, bus.err_count}, 32'hFF);
    bus.err_count_clr = 1'b1;
    step();
    bus.err_count_clr = 1'b0;
    step();
    check("errcnt_clr", {24'd0, bus.err_count}, 0);
    // clear coinciding with a failing verdict: the increment wins
    pulse_clear();
    bus.eop           = 1'b1;
    bus.err_count_clr = 1'b1;
    begin
      exp_t e;
      e.cyc = 0;
      e.ok  = 1'b0;
      e.cnt = 0;
      push_exp(e);
    end
    step();
    bus.eop           = 1'b0;
    bus.err_count_clr = 1'b0;
    repeat (2) step();
    check("errcnt_clr_vs_inc", {24'd0, bus.err_count}, 1);
`endif

    repeat (5) step();
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
